demux8_deser: RTL and testbench

- Receive-side counterpart of the 8:1 bit-select mux: reassembles an 8-bit word from a serial bit stream, LSB first.
- A sender sweeps its select 0..7 and emits one bit per valid cycle; this block steers bit k into data[k] with an internal 3-bit index (the demux select).
- Completed words are presented on a valid/ready output with one-word buffering and an overrun flag.

---
 rtl/demux_pkg.sv | 12 +
 rtl/bit_index_ctr.sv | 50 +++++
 rtl/demux8_deser.sv | 101 ++++++++++
 tb/tb_demux8_deser.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and sizes for the serial-to-parallel word demux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    localparam int WORD_W = 8;
    localparam int IDX_W  = 3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;

endpackage : demux_pkg

// File: rtl/bit_index_ctr.sv
// Bit-position counter: wraps 0..2**CNT_W-1, sync clear, advance on enable.
// Latency: cnt_o registered; idx_o/last_o combinational from cnt_q and clr_i.
// Backpressure: none, en_i simply holds the count when low.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clr_i         - restart at position 0 (takes effect for this cycle's index)
//   en_i          - a bit is accepted this cycle; advance past idx_o
//   cnt_o         - registered count (next write position)
//   idx_o         - write position used this cycle (0 when clr_i)
//   last_o        - idx_o is the final position of the word
module bit_index_ctr #(
    parameter int CNT_W = demux_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] idx_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // A clear applies to the current bit, so the write index is forced to 0
        // in the same cycle rather than one cycle later.
        idx_o = clr_i ? '0 : cnt_q;
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = idx_o + 1'b1;   // natural wrap at 2**CNT_W
        end else if (clr_i) begin
            cnt_d = '0;
        end
    end

    assign last_o = &idx_o;
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : bit_index_ctr

// File: rtl/demux8_deser.sv
// Reassembles LSB-first serial bits into WIDTH-bit words, one-word output buffer.
// Latency: word_valid rises on the edge that samples the last bit of a word.
// Backpressure: word_valid/word_ready; a word completing into a full slot is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   bit_in, bit_valid, frame_start    - serial input; frame_start marks bit 0
//   sel                               - registered index of the next bit
//   word_out, word_valid, word_ready  - assembled word handshake
//   overrun                           - sticky word-dropped flag
module demux8_deser #(
    parameter int WIDTH = demux_pkg::WORD_W,
    parameter int IDX_W = demux_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [IDX_W-1:0] sel,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun
);

    if (WIDTH < 2 || WIDTH != (1 << IDX_W)) begin : g_bad_param
        $error("demux8_deser: WIDTH must be a power of 2 >= 2 and equal 2**IDX_W");
    end

    logic [IDX_W-1:0] idx;
    logic             last_bit;

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] word_q,   word_d;
    logic             vld_q,    vld_d;
    logic             ovr_q,    ovr_d;
    logic             complete;
    logic             consume;

    bit_index_ctr #(
        .CNT_W (IDX_W)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_start),
        .en_i   (bit_valid),
        .cnt_o  (sel),
        .idx_o  (idx),
        .last_o (last_bit)
    );

    assign complete = bit_valid && last_bit;
    assign consume  = vld_q && word_ready;

    always_comb begin
        shadow_d = shadow_q;
        word_d   = word_q;
        vld_d    = vld_q;
        ovr_d    = ovr_q;

        // An aborted partial word needs no clearing: every position is
        // rewritten before the next completion can observe it.
        if (bit_valid) begin
            shadow_d[idx] = bit_in;
        end

        if (consume) begin
            vld_d = 1'b0;
        end

        // shadow_d already carries the final bit merged this cycle.
        if (complete) begin
            if (!vld_q || word_ready) begin
                word_d = shadow_d;
                vld_d  = 1'b1;
            end else begin
                ovr_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            word_q   <= '0;
            vld_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            word_q   <= word_d;
            vld_q    <= vld_d;
            ovr_q    <= ovr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = vld_q;
    assign overrun    = ovr_q;

endmodule : demux8_deser

// File: tb/tb_demux8_deser.sv
// Scoreboard bench for demux8_deser: stimulus pushes expected words, a monitor
// pops them whenever a new word is presented; directed checks cover the rest.
module tb_demux8_deser;

    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       frame_start;
    logic [2:0] sel;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    time        new_times[$];

    always #(PERIOD/2) clk = ~clk;

    demux8_deser dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .sel         (sel),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a word is newly presented when valid is high and the previous
    // sampled cycle was either idle or a consume.
    logic pv = 1'b0;
    logic pr = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (word_valid && (!pv || pr)) begin
                new_times.push_back($time);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'h0, word_out}, 32'hFFFF_FFFF);
                end else begin
                    check("scoreboard_word", {24'h0, word_out}, {24'h0, exp_q.pop_front()});
                end
            end
            pv = word_valid;
            pr = word_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        bit_in      = b;
        frame_start = fs;
        bit_valid   = 1'b1;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int max_gap);
        for (int i = 0; i < 8; i++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(0, max_gap);
                for (int k = 0; k < g; k++) tick();
            end
            send_bit(w[i], i == 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"},      {29'h0, sel},        32'h0);
        check({tag, "_valid"},    {31'h0, word_valid}, 32'h0);
        check({tag, "_overrun"},  {31'h0, overrun},    32'h0);
        check({tag, "_word_out"}, {24'h0, word_out},   32'h0);
    endtask

    initial begin
        #(100000 * PERIOD);
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; word_ready = 1'b0;
        tick(); tick();
        check_reset_state("por");
        rst = 1'b0;

        // Reset mid-word: 3 bits, then 2 reset cycles.
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        check("partial_sel", {29'h0, sel}, 32'd3);
        rst = 1'b1; tick(); tick();
        check_reset_state("midword_rst");
        rst = 1'b0;
        word_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 0);
        @(negedge clk);
        check("a5_valid", {31'h0, word_valid}, 32'h1);
        check("a5_word",  {24'h0, word_out},   32'hA5);
        tick();

        // Basic word with sel sweep and one-cycle valid pulse.
        exp_q.push_back(8'h01);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sel_%0d", i), {29'h0, sel}, i);
            send_bit(i == 0, i == 0);
        end
        check("sel_wrap", {29'h0, sel}, 32'h0);
        @(negedge clk);
        check("basic_valid_hi", {31'h0, word_valid}, 32'h1);
        check("basic_word",     {24'h0, word_out},   32'h01);
        @(negedge clk);
        check("basic_valid_lo", {31'h0, word_valid}, 32'h0);
        tick();

        // Gaps and stall.
        word_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 3);
        tick(); tick(); tick();
        check("stall_valid", {31'h0, word_valid}, 32'h1);
        check("stall_word",  {24'h0, word_out},   32'h3C);
        word_ready = 1'b1; tick(); word_ready = 1'b0;
        check("consumed_valid", {31'h0, word_valid}, 32'h0);
        check("held_word",      {24'h0, word_out},   32'h3C);

        // Back-to-back with ready held.
        word_ready = 1'b1;
        new_times.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        tick(); tick();
        check("b2b_count", new_times.size(), 32'd2);
        if (new_times.size() == 2)
            check("b2b_spacing", 32'(new_times[1] - new_times[0]), 32'(8 * PERIOD));
        check("b2b_overrun", {31'h0, overrun},    32'h0);
        check("b2b_idle",    {31'h0, word_valid}, 32'h0);

        // Overrun: second word dropped while slot is full.
        word_ready = 1'b0;
        exp_q.push_back(8'h55);
        send_word(8'h55, 0);
        send_word(8'hAA, 0);
        tick();
        check("ovr_word",  {24'h0, word_out},   32'h55);
        check("ovr_flag",  {31'h0, overrun},    32'h1);
        check("ovr_valid", {31'h0, word_valid}, 32'h1);
        word_ready = 1'b1; tick(); tick();
        check("ovr_sticky",   {31'h0, overrun},    32'h1);
        check("ovr_consumed", {31'h0, word_valid}, 32'h0);

        // Resync: 5 partial bits aborted by a new frame_start.
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        check("resync_sel", {29'h0, sel}, 32'd5);
        exp_q.push_back(8'hF0);
        send_word(8'hF0, 0);
        @(negedge clk);
        check("resync_word", {24'h0, word_out}, 32'hF0);
        tick(); tick();

        // Overrun clears only on reset.
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_clears_overrun", {31'h0, overrun}, 32'h0);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux8_deser
